// File: rtl/pipe_hazard_regs_pkg.sv
// Shared widths, reset values and stage bundle layouts for the fetch/decode
// hazard registers.
package pipe_hazard_regs_pkg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 16;

   localparam logic [DATA_W-1:0] PC_RST      = '0;
   localparam logic [DATA_W-1:0] PC_STEP     = 32'd4;
   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

   typedef struct packed {
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] instr;
      logic              valid;
   } if_id_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic              valid;
   } id_ex_t;

   // Zero ctrl means no DM read and no register write, so a bubble is inert.
   localparam if_id_t IF_ID_BUBBLE = '{default: '0};
   localparam id_ex_t ID_EX_BUBBLE = '{ctrl: BUBBLE_CTRL, default: '0};

endpackage

// File: rtl/pipe_hazard_regs_pipe_reg.sv
// Generic pipeline register: synchronous clear beats hold, reset loads the
// clear value.
module pipe_reg #(
   parameter int           W       = 1,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n)      q <= CLR_VAL;
      else if (clear)  q <= CLR_VAL;
      else if (!hold)  q <= d;
   end

endmodule

// File: rtl/pipe_hazard_regs.sv
// PC, IF/ID and ID/EX registers with stall, flush and branch-redirect control,
// plus a saturating count of load-use bubbles.
module pipe_hazard_regs
   import pipe_hazard_regs_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              PC_stall_i,
   input  logic              IF_ID_stall_i,
   input  logic              ID_EX_flush_i,
   input  logic              branch_taken_i,
   input  logic [DATA_W-1:0] branch_target_i,
   input  logic [DATA_W-1:0] IM_instr_i,
   input  logic [CTRL_W-1:0] ID_ctrl_i,
   input  logic [DATA_W-1:0] ID_rs_data_i,
   input  logic [DATA_W-1:0] ID_rt_data_i,
   input  logic [DATA_W-1:0] ID_imm_i,
   output logic [DATA_W-1:0] PC_o,
   output logic [DATA_W-1:0] IF_ID_pc4_o,
   output logic [DATA_W-1:0] IF_ID_instr_o,
   output logic              IF_ID_valid_o,
   output logic [CTRL_W-1:0] ID_EX_ctrl_o,
   output logic [DATA_W-1:0] ID_EX_rs_data_o,
   output logic [DATA_W-1:0] ID_EX_rt_data_o,
   output logic [DATA_W-1:0] ID_EX_imm_o,
   output logic [REG_W-1:0]  ID_EX_rs_o,
   output logic [REG_W-1:0]  ID_EX_rt_o,
   output logic [REG_W-1:0]  ID_EX_rd_o,
   output logic              ID_EX_valid_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pc4;
   logic [CNT_W-1:0]  cnt_q;
   if_id_t            if_id_d, if_id_q;
   id_ex_t            id_ex_d, id_ex_q;

   assign pc4 = pc_q + PC_STEP;

   always_ff @(posedge clk_i) begin
      if (!rst_i)               pc_q <= PC_RST;
      else if (branch_taken_i)  pc_q <= branch_target_i;
      else if (!PC_stall_i)     pc_q <= pc4;
   end

   // A flush that coincides with a branch is a branch squash, not a load-use bubble.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         cnt_q <= '0;
      else if (ID_EX_flush_i && !branch_taken_i && cnt_q != CNT_MAX)
         cnt_q <= cnt_q + 1'b1;
   end

   assign if_id_d = '{pc4: pc4, instr: IM_instr_i, valid: 1'b1};

   assign id_ex_d = '{ctrl:    ID_ctrl_i,
                      rs_data: ID_rs_data_i,
                      rt_data: ID_rt_data_i,
                      imm:     ID_imm_i,
                      rs:      if_id_q.instr[25:21],
                      rt:      if_id_q.instr[20:16],
                      rd:      if_id_q.instr[15:11],
                      valid:   if_id_q.valid};

   pipe_reg #(.W($bits(if_id_t)), .CLR_VAL(IF_ID_BUBBLE)) u_if_id (
      .clk   (clk_i),
      .rst_n (rst_i),
      .hold  (IF_ID_stall_i),
      .clear (branch_taken_i),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   pipe_reg #(.W($bits(id_ex_t)), .CLR_VAL(ID_EX_BUBBLE)) u_id_ex (
      .clk   (clk_i),
      .rst_n (rst_i),
      .hold  (1'b0),
      .clear (branch_taken_i | ID_EX_flush_i),
      .d     (id_ex_d),
      .q     (id_ex_q)
   );

   assign PC_o            = pc_q;
   assign stall_cnt_o     = cnt_q;
   assign IF_ID_pc4_o     = if_id_q.pc4;
   assign IF_ID_instr_o   = if_id_q.instr;
   assign IF_ID_valid_o   = if_id_q.valid;
   assign ID_EX_ctrl_o    = id_ex_q.ctrl;
   assign ID_EX_rs_data_o = id_ex_q.rs_data;
   assign ID_EX_rt_data_o = id_ex_q.rt_data;
   assign ID_EX_imm_o     = id_ex_q.imm;
   assign ID_EX_rs_o      = id_ex_q.rs;
   assign ID_EX_rt_o      = id_ex_q.rt;
   assign ID_EX_rd_o      = id_ex_q.rd;
   assign ID_EX_valid_o   = id_ex_q.valid;

endmodule

// File: tb/tb_pipe_hazard_regs.sv
// Directed and randomized checks of the hazard registers against a
// cycle-level reference model of the stage update rules.
module tb_pipe_hazard_regs;

   logic        clk_i = 1'b0;
   logic        rst_i, PC_stall_i, IF_ID_stall_i, ID_EX_flush_i, branch_taken_i;
   logic [31:0] branch_target_i, IM_instr_i, ID_rs_data_i, ID_rt_data_i, ID_imm_i;
   logic [15:0] ID_ctrl_i;
   logic [31:0] PC_o, IF_ID_pc4_o, IF_ID_instr_o, ID_EX_rs_data_o, ID_EX_rt_data_o, ID_EX_imm_o;
   logic        IF_ID_valid_o, ID_EX_valid_o;
   logic [15:0] ID_EX_ctrl_o, stall_cnt_o;
   logic [4:0]  ID_EX_rs_o, ID_EX_rt_o, ID_EX_rd_o;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_pc, m_pc4, m_instr, m_rsd, m_rtd, m_imm;
   logic        m_ifv, m_exv;
   logic [15:0] m_ctrl, m_cnt;
   logic [4:0]  m_rs, m_rt, m_rd;

   always #5 clk_i = ~clk_i;

   pipe_hazard_regs dut (
      .clk_i(clk_i), .rst_i(rst_i), .PC_stall_i(PC_stall_i), .IF_ID_stall_i(IF_ID_stall_i),
      .ID_EX_flush_i(ID_EX_flush_i), .branch_taken_i(branch_taken_i),
      .branch_target_i(branch_target_i), .IM_instr_i(IM_instr_i), .ID_ctrl_i(ID_ctrl_i),
      .ID_rs_data_i(ID_rs_data_i), .ID_rt_data_i(ID_rt_data_i), .ID_imm_i(ID_imm_i),
      .PC_o(PC_o), .IF_ID_pc4_o(IF_ID_pc4_o), .IF_ID_instr_o(IF_ID_instr_o),
      .IF_ID_valid_o(IF_ID_valid_o), .ID_EX_ctrl_o(ID_EX_ctrl_o),
      .ID_EX_rs_data_o(ID_EX_rs_data_o), .ID_EX_rt_data_o(ID_EX_rt_data_o),
      .ID_EX_imm_o(ID_EX_imm_o), .ID_EX_rs_o(ID_EX_rs_o), .ID_EX_rt_o(ID_EX_rt_o),
      .ID_EX_rd_o(ID_EX_rd_o), .ID_EX_valid_o(ID_EX_valid_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: the model applies the stage rules to the inputs present at the edge.
   task automatic tick(input bit do_check);
      logic [31:0] old_pc, old_instr;
      logic        old_ifv;
      @(posedge clk_i);
      old_pc = m_pc; old_instr = m_instr; old_ifv = m_ifv;
      if (!rst_i) begin
         m_pc = 0; m_pc4 = 0; m_instr = 0; m_ifv = 0;
         m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_exv = 0;
         m_cnt = 0;
      end else begin
         if (branch_taken_i)   m_pc = branch_target_i;
         else if (!PC_stall_i) m_pc = old_pc + 4;
         if (branch_taken_i) begin
            m_pc4 = 0; m_instr = 0; m_ifv = 0;
         end else if (!IF_ID_stall_i) begin
            m_pc4 = old_pc + 4; m_instr = IM_instr_i; m_ifv = 1;
         end
         if (branch_taken_i || ID_EX_flush_i) begin
            m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_exv = 0;
         end else begin
            m_ctrl = ID_ctrl_i; m_rsd = ID_rs_data_i; m_rtd = ID_rt_data_i; m_imm = ID_imm_i;
            m_rs = old_instr[25:21]; m_rt = old_instr[20:16]; m_rd = old_instr[15:11];
            m_exv = old_ifv;
         end
         if (ID_EX_flush_i && !branch_taken_i && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
      end
      #1;
      if (do_check) begin
         chk("pc", PC_o, m_pc);
         chk("if_id", {IF_ID_pc4_o, IF_ID_instr_o, IF_ID_valid_o}, {m_pc4, m_instr, m_ifv});
         chk("id_ex_data", {ID_EX_ctrl_o, ID_EX_rs_data_o, ID_EX_rt_data_o, ID_EX_imm_o},
             {m_ctrl, m_rsd, m_rtd, m_imm});
         chk("id_ex_idx", {ID_EX_rs_o, ID_EX_rt_o, ID_EX_rd_o, ID_EX_valid_o},
             {m_rs, m_rt, m_rd, m_exv});
         chk("stall_cnt", stall_cnt_o, m_cnt);
      end
   endtask

   task automatic set_ctl(input logic r, ps, is, fl, br, input logic [31:0] tgt);
      rst_i = r; PC_stall_i = ps; IF_ID_stall_i = is; ID_EX_flush_i = fl;
      branch_taken_i = br; branch_target_i = tgt;
   endtask

   initial begin
      set_ctl(0, 0, 0, 0, 0, 0);
      IM_instr_i = 32'h8C220004;
      ID_ctrl_i = 16'h00A5; ID_rs_data_i = 32'h11111111; ID_rt_data_i = 32'h22222222;
      ID_imm_i = 32'h00000004;

      // reset for two cycles (model state initialised by the reset tick)
      m_cnt = 0; m_pc = 0; m_instr = 0; m_ifv = 0;
      tick(0);
      tick(1);
      chk("rst_pc", PC_o, 32'h0);
      chk("rst_valid", {IF_ID_valid_o, ID_EX_valid_o}, 2'b00);

      // plain fetch sequence
      rst_i = 1;
      tick(1);
      chk("fetch_pc4", PC_o, 32'h4);
      chk("fetch_instr", IF_ID_instr_o, 32'h8C220004);
      chk("fetch_ifpc4", IF_ID_pc4_o, 32'h4);
      tick(1);
      chk("fetch_pc8", PC_o, 32'h8);
      chk("fetch_rs_rt", {ID_EX_rs_o, ID_EX_rt_o, ID_EX_valid_o}, {5'd1, 5'd2, 1'b1});

      // one-cycle load-use stall at PC 8
      set_ctl(1, 1, 1, 1, 0, 0);
      tick(1);
      chk("stall_pc", PC_o, 32'h8);
      chk("stall_ifid", {IF_ID_pc4_o, IF_ID_valid_o}, {32'h8, 1'b1});
      chk("stall_bubble", {ID_EX_valid_o, ID_EX_ctrl_o}, 17'h0);
      chk("stall_cnt1", stall_cnt_o, 16'd1);

      // branch wins over stall/flush
      set_ctl(1, 1, 1, 1, 1, 32'h40);
      tick(1);
      chk("br_pc", PC_o, 32'h40);
      chk("br_valids", {IF_ID_valid_o, ID_EX_valid_o}, 2'b00);
      chk("br_cnt", stall_cnt_o, 16'd1);

      // PC wrap
      set_ctl(1, 0, 0, 0, 1, 32'hFFFFFFFC);
      tick(1);
      set_ctl(1, 0, 0, 0, 0, 0);
      tick(1);
      chk("wrap_pc", PC_o, 32'h0);
      chk("wrap_ifpc4", IF_ID_pc4_o, 32'h0);

      // reset in the middle of a stall at PC 0x20
      set_ctl(1, 0, 0, 0, 1, 32'h20);
      tick(1);
      set_ctl(1, 1, 1, 1, 0, 0);
      tick(1);
      chk("midstall_pc", PC_o, 32'h20);
      set_ctl(0, 1, 1, 1, 0, 0);
      tick(1);
      chk("midrst_pc", PC_o, 32'h0);
      chk("midrst_state", {IF_ID_valid_o, ID_EX_valid_o, stall_cnt_o}, 18'h0);
      set_ctl(1, 0, 0, 0, 0, 0);
      tick(1);
      chk("post_rst_pc", PC_o, 32'h4);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst_i           = ($urandom_range(63) != 0);
         PC_stall_i      = ($urandom_range(3) == 0);
         IF_ID_stall_i   = ($urandom_range(3) == 0);
         ID_EX_flush_i   = ($urandom_range(3) == 0);
         branch_taken_i  = ($urandom_range(7) == 0);
         branch_target_i = $urandom & 32'hFFFFFFFC;
         IM_instr_i      = $urandom;
         ID_ctrl_i       = 16'($urandom);
         ID_rs_data_i    = $urandom;
         ID_rt_data_i    = $urandom;
         ID_imm_i        = $urandom;
         tick(1);
      end

      // counter saturation under a long flush
      set_ctl(0, 0, 0, 0, 0, 0);
      tick(1);
      set_ctl(1, 1, 1, 1, 0, 0);
      for (int i = 0; i < 65534; i++) tick(0);
      chk("sat_fffe", stall_cnt_o, 16'hFFFE);
      tick(1);
      chk("sat_ffff", stall_cnt_o, 16'hFFFF);
      for (int i = 0; i < 5; i++) tick(0);
      tick(1);
      chk("sat_hold", stall_cnt_o, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
